// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared definitions for the GF(2^M) inverse unit.
//   CMD_NOP / CMD_INV : command opcodes on cmd_op (codes 2-3 are reserved and act as NOP)
//   state_t           : inverter FSM state encoding
//   step_bound()      : maximum number of Euclidean steps for a field of degree m
package gf2m_pkg;

    localparam logic [1:0] CMD_NOP = 2'd0;
    localparam logic [1:0] CMD_INV = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Every binary Euclidean step removes at least half a bit from deg(u)+deg(v),
    // so 4*m steps always suffice for an irreducible polynomial of degree m.
    function automatic int unsigned step_bound(input int unsigned m);
        return 32'd4 * m;
    endfunction

endpackage

// File: rtl/gf2m_half_step.sv
// gf2m_half_step: computes g * x^-1 mod f, i.e. (g[0] ? g ^ f : g) >> 1.
//   g  in  M    current coefficient (degree < M)
//   f  in  M+1  reduction polynomial (bit 0 and bit M set)
//   q  out M    g divided by x modulo f
module gf2m_half_step
    import gf2m_pkg::*;
#(
    parameter int M = 233
) (
    input  logic [M-1:0] g,
    input  logic [M:0]   f,
    output logic [M-1:0] q
);

    logic [M:0] sum_s;

    // Add f when g is odd so the low bit clears, then drop it.
    always_comb begin
        sum_s = {1'b0, g};
        if (g[0]) begin
            sum_s = {1'b0, g} ^ f;
        end else begin
            sum_s = {1'b0, g};
        end
        q = sum_s[M:1];
    end

endmodule

// File: rtl/gf2m_inverse_unit.sv
// gf2m_inverse_unit: GF(2^M) inverter with a DEPTH-entry operand register file and a
// programmable reduction polynomial. CMD_INV writes regfile[dst] = regfile[src]^-1 mod f
// using a binary extended Euclidean datapath, one step per clock.
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data         host write into the register file (dropped while busy)
//   rd_addr/rd_data               host read, registered, one cycle latency
//   poly_we/poly_in               load reduction polynomial f (dropped while busy)
//   cmd_valid/cmd_ready           command handshake, ready only in IDLE
//   cmd_op/cmd_src/cmd_dst        opcode, source and destination addresses
//   busy                          high from command accept through WRITE
//   done                          one-cycle pulse after the result (or NOP) completes
//   err_zero                      sticky flag, operand was zero; cleared by the next INV
// Build option:
//   GF2M_INV_CONST_TIME_EN        when defined, RUN always lasts exactly 4*M cycles so the
//                                 latency does not depend on the operand value.
module gf2m_inverse_unit
    import gf2m_pkg::*;
#(
    parameter int M      = 233,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [M-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [M-1:0]      rd_data,
    input  logic              poly_we,
    input  logic [M:0]        poly_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              busy,
    output logic              done,
    output logic              err_zero
);

    localparam int CNT_W = $clog2(step_bound(M) + 1);

    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(step_bound(M) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = CNT_W'(step_bound(M));
    localparam logic [M:0]       U_ONE_C    = {{M{1'b0}}, 1'b1};
    localparam logic [M-1:0]     G_ONE_C    = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M-1:0]     G_ZERO_C   = {M{1'b0}};

    logic [M-1:0]      regfile_r [DEPTH];
    logic [M-1:0]      rd_data_r;
    logic [M:0]        poly_r;
    state_t            state_r;
    logic              busy_r;
    logic              done_r;
    logic              err_zero_r;
    logic              cmd_ready_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    // u and v share the M+1-bit width because v starts as f.
    logic [M:0]        u_r;
    logic [M:0]        v_r;
    logic [M-1:0]      g1_r;
    logic [M-1:0]      g2_r;
    logic [M-1:0]      result_r;
    logic [CNT_W-1:0]  cnt_r;
`ifdef GF2M_INV_CONST_TIME_EN
    logic              exited_r;
`endif

    logic [M-1:0] operand_s;
    logic         op_zero_s;
    logic         op_one_s;
    logic [M-1:0] g1_half_s;
    logic [M-1:0] g2_half_s;
    logic [M:0]   u_nx_s;
    logic [M:0]   v_nx_s;
    logic [M-1:0] g1_nx_s;
    logic [M-1:0] g2_nx_s;

    assign operand_s = regfile_r[src_r];
    assign op_zero_s = (operand_s == G_ZERO_C);
    assign op_one_s  = (operand_s == G_ONE_C);

    gf2m_half_step #(.M(M)) u_half_g1 (.g(g1_r), .f(poly_r), .q(g1_half_s));
    gf2m_half_step #(.M(M)) u_half_g2 (.g(g2_r), .f(poly_r), .q(g2_half_s));

    // One binary Euclidean step: halve an even side, otherwise subtract the smaller from the larger.
    always_comb begin
        u_nx_s  = u_r;
        v_nx_s  = v_r;
        g1_nx_s = g1_r;
        g2_nx_s = g2_r;
        if (!u_r[0]) begin
            u_nx_s  = u_r >> 1'b1;
            g1_nx_s = g1_half_s;
        end else if (!v_r[0]) begin
            v_nx_s  = v_r >> 1'b1;
            g2_nx_s = g2_half_s;
        end else if (u_r >= v_r) begin
            u_nx_s  = u_r ^ v_r;
            g1_nx_s = g1_r ^ g2_r;
        end else begin
            v_nx_s  = v_r ^ u_r;
            g2_nx_s = g2_r ^ g1_r;
        end
    end

    // Command FSM, Euclidean datapath registers, polynomial register and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_zero_r  <= 1'b0;
            cmd_ready_r <= 1'b1;
            poly_r      <= {(M+1){1'b0}};
            src_r       <= {ADDR_W{1'b0}};
            dst_r       <= {ADDR_W{1'b0}};
            u_r         <= {(M+1){1'b0}};
            v_r         <= {(M+1){1'b0}};
            g1_r        <= G_ZERO_C;
            g2_r        <= G_ZERO_C;
            result_r    <= G_ZERO_C;
            cnt_r       <= {CNT_W{1'b0}};
`ifdef GF2M_INV_CONST_TIME_EN
            exited_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (poly_we && !busy_r) begin
                poly_r <= poly_in;
            end
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == CMD_INV) begin
                            state_r     <= S_LOAD;
                            busy_r      <= 1'b1;
                            cmd_ready_r <= 1'b0;
                            src_r       <= cmd_src;
                            dst_r       <= cmd_dst;
                            err_zero_r  <= 1'b0;
                        end else begin
                            // NOP and reserved opcodes complete immediately.
                            done_r <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    u_r      <= {1'b0, operand_s};
                    v_r      <= poly_r;
                    g1_r     <= G_ONE_C;
                    g2_r     <= G_ZERO_C;
                    cnt_r    <= {CNT_W{1'b0}};
                    // For operands 0 and 1 the result equals the operand itself.
                    result_r <= operand_s;
                    if (op_zero_s) begin
                        err_zero_r <= 1'b1;
                    end
`ifdef GF2M_INV_CONST_TIME_EN
                    exited_r <= op_zero_s || op_one_s;
                    state_r  <= S_RUN;
`else
                    state_r  <= (op_zero_s || op_one_s) ? S_WRITE : S_RUN;
`endif
                end
                S_RUN: begin
                    if (cnt_r != CNT_MAX_C) begin
                        cnt_r <= cnt_r + CNT_ONE_C;
                    end
`ifdef GF2M_INV_CONST_TIME_EN
                    // Once an exit is seen the datapath freezes until the step budget runs out.
                    if (!exited_r) begin
                        u_r  <= u_nx_s;
                        v_r  <= v_nx_s;
                        g1_r <= g1_nx_s;
                        g2_r <= g2_nx_s;
                        if (u_nx_s == U_ONE_C) begin
                            result_r <= g1_nx_s;
                            exited_r <= 1'b1;
                        end else if (v_nx_s == U_ONE_C) begin
                            result_r <= g2_nx_s;
                            exited_r <= 1'b1;
                        end
                    end
                    if (cnt_r == CNT_LAST_C) begin
                        state_r <= S_WRITE;
                    end
`else
                    u_r  <= u_nx_s;
                    v_r  <= v_nx_s;
                    g1_r <= g1_nx_s;
                    g2_r <= g2_nx_s;
                    if (u_nx_s == U_ONE_C) begin
                        result_r <= g1_nx_s;
                        state_r  <= S_WRITE;
                    end else if (v_nx_s == U_ONE_C) begin
                        result_r <= g2_nx_s;
                        state_r  <= S_WRITE;
                    end else if (cnt_r == CNT_LAST_C) begin
                        // Reducible f: give up at the step bound, data is meaningless.
                        state_r <= S_WRITE;
                    end
`endif
                end
                S_WRITE: begin
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    done_r      <= 1'b1;
                end
                default: begin
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Register file write port: result write-back in WRITE, otherwise host writes when not busy.
    // A reset edge performs no write, so an aborted command leaves dst untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == S_WRITE) begin
                regfile_r[dst_r] <= result_r;
            end else if (wr_en && !busy_r) begin
                regfile_r[wr_addr] <= wr_data;
            end
        end
    end

    // Registered host read port, live in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= G_ZERO_C;
        end else begin
            rd_data_r <= regfile_r[rd_addr];
        end
    end

    assign rd_data   = rd_data_r;
    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_zero  = err_zero_r;

endmodule

// File: tb/tb_gf2m_inverse_unit.sv
// tb_gf2m_inverse_unit: scoreboard bench for gf2m_inverse_unit at M=8, f=0x11B.
// Stimulus pushes expected results (from a multiply-and-search field model) into a queue;
// a monitor pops and checks them whenever done pulses, and also serves readback probes.
module tb_gf2m_inverse_unit;

    localparam int M      = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int F_POLY = 32'h11B;
    localparam int BOUND  = 4 * M;
`ifdef GF2M_INV_CONST_TIME_EN
    localparam int LAT_MIN = 3 + BOUND;
    localparam int LAT_MAX = 3 + BOUND;
    localparam int LAT_ONE = 3 + BOUND;
`else
    localparam int LAT_MIN = 3;
    localparam int LAT_MAX = 3 + BOUND;
    localparam int LAT_ONE = 3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [M-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [M-1:0]  rd_data;
    logic          poly_we;
    logic [M:0]    poly_in;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic          busy;
    logic          done;
    logic          err_zero;

    gf2m_inverse_unit #(.M(M), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .poly_we(poly_we), .poly_in(poly_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .busy(busy), .done(done), .err_zero(err_zero)
    );

    typedef struct {
        int dst;
        int data;
        int err;
        int acc_cyc;
        int operand;
        bit is_inv;
    } exp_t;

    typedef struct {
        int addr;
        int data;
    } probe_t;

    exp_t   exp_q[$];
    probe_t probe_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int n_pushed = 0;
    int n_seen = 0;
    int n_probe_pushed = 0;
    int n_probed = 0;
    int model_rf[DEPTH];
    int model_err = 0;
    int lat_of[int];
    int cyc = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time accept-to-done latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [31:0] act, input int exp_v);
        n_checks++;
        if (act !== 32'(exp_v)) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    // Field multiply by shift-and-add with reduction by f.
    function automatic int gf_mul(input int a, input int b);
        int r = 0;
        int x = a;
        for (int i = 0; i < M; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ x;
            x = x << 1;
            if ((x & (1 << M)) != 0) x = x ^ F_POLY;
        end
        return r;
    endfunction

    // Inverse by exhaustive search; 0 maps to 0.
    function automatic int gf_inv(input int a);
        if (a == 0) return 0;
        for (int b = 1; b < (1 << M); b++) begin
            if (gf_mul(a, b) == 1) return b;
        end
        return -1;
    endfunction

    task automatic host_write(input int addr, input int data, input bit expect_taken);
        wr_en = 1'b1;
        wr_addr = AW'(addr);
        wr_data = M'(data);
        @(negedge clk);
        wr_en = 1'b0;
        if (expect_taken) model_rf[addr] = data;
    endtask

    task automatic load_poly(input int f);
        poly_we = 1'b1;
        poly_in = (M+1)'(f);
        @(negedge clk);
        poly_we = 1'b0;
    endtask

    task automatic probe(input int addr, input int data);
        probe_t p;
        p.addr = addr;
        p.data = data;
        probe_q.push_back(p);
        n_probe_pushed++;
    endtask

    // Present a command, hold it until accepted, and record the expected outcome.
    task automatic issue(input int op, input int src, input int dst, input bit track);
        exp_t e;
        int t = 0;
        cmd_valid = 1'b1;
        cmd_op = 2'(op);
        cmd_src = AW'(src);
        cmd_dst = AW'(dst);
        while (cmd_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
            cmd_valid = 1'b0;
            return;
        end
        if (track) begin
            e.dst = dst;
            e.acc_cyc = cyc + 1;
            e.is_inv = (op == 1);
            if (op == 1) begin
                e.operand = model_rf[src];
                e.data = gf_inv(e.operand);
                e.err = (e.operand == 0) ? 1 : 0;
                model_err = e.err;
                model_rf[dst] = e.data;
            end else begin
                e.operand = 0;
                e.data = model_rf[dst];
                e.err = model_err;
            end
            exp_q.push_back(e);
            n_pushed++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait until every expected result and probe has been checked by the monitor.
    task automatic wait_quiet();
        int t = 0;
        while ((n_seen != n_pushed || n_probed != n_probe_pushed) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL completion_timeout: seen %0d of %0d results, %0d of %0d probes",
                     n_seen, n_pushed, n_probed, n_probe_pushed);
            exp_q.delete();
            probe_q.delete();
            n_pushed = n_seen;
            n_probe_pushed = n_probed;
        end
        @(negedge clk);
    endtask

    // Monitor: checks each done pulse against the scoreboard, then serves readback probes.
    initial begin : monitor
        exp_t e;
        probe_t p;
        int lat;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with no command outstanding (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    lat = cyc - e.acc_cyc + 1;
                    check("err_zero", 32'(err_zero), e.err);
                    check("busy_at_done", 32'(busy), 0);
                    if (e.is_inv) begin
                        n_checks++;
                        if (lat < LAT_MIN || lat > LAT_MAX) begin
                            n_fail++;
                            $display("FAIL latency_range: actual %0d, required %0d..%0d", lat, LAT_MIN, LAT_MAX);
                        end
                        if (e.operand == 1) check("latency_one", 32'(lat), LAT_ONE);
                        if (lat_of.exists(e.operand)) check("latency_stable", 32'(lat), lat_of[e.operand]);
                        else lat_of[e.operand] = lat;
                    end else begin
                        check("nop_latency", 32'(lat), 1);
                    end
                    rd_addr = AW'(e.dst);
                    @(negedge clk);
                    check("done_pulse", 32'(done), 0);
                    check("result", 32'(rd_data), e.data);
                    if (e.is_inv && e.operand != 0) check("a_times_inv", 32'(gf_mul(e.operand, int'(rd_data))), 1);
                    n_seen++;
                end
            end else if (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                rd_addr = AW'(p.addr);
                @(negedge clk);
                check("probe", 32'(rd_data), p.data);
                n_probed++;
            end
        end
    end

    // Stimulus: directed corner cases followed by a shuffled sweep over all nonzero operands.
    initial begin : stimulus
        int order[$];
        int tmp;
        int j;
        int src;
        int dst;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        poly_we = 1'b0;
        poly_in = '0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_src = '0;
        cmd_dst = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err_zero", 32'(err_zero), 0);
        check("reset_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 1);

        load_poly(F_POLY);
        for (int i = 0; i < DEPTH; i++) host_write(i, int'($urandom_range(1, 255)), 1'b1);
        host_write(3, 32'h53, 1'b1);

        // INV 3->4 with a dropped host write and a held second command.
        issue(1, 3, 4, 1'b1);
        wr_en = 1'b1;
        wr_addr = AW'(4);
        wr_data = M'(32'h77);
        poly_we = 1'b1;
        poly_in = (M+1)'(32'h1FF);
        @(negedge clk);
        wr_en = 1'b0;
        poly_we = 1'b0;
        check("busy_during_run", 32'(busy), 1);
        check("ready_low_while_busy", 32'(cmd_ready), 0);
        issue(1, 3, 7, 1'b1);
        wait_quiet();
        probe(4, 32'hCA);
        wait_quiet();

        // Operand 1, in place: minimum latency.
        host_write(0, 1, 1'b1);
        issue(1, 0, 0, 1'b1);
        wait_quiet();

        // Zero operand sets err_zero; NOP keeps it; reserved op is a NOP; next INV clears it.
        host_write(5, 0, 1'b1);
        issue(1, 5, 6, 1'b1);
        wait_quiet();
        issue(0, 2, 2, 1'b1);
        wait_quiet();
        issue(3, 1, 1, 1'b1);
        wait_quiet();
        issue(1, 3, 8, 1'b1);
        wait_quiet();

        // Reset in the 5th RUN cycle aborts with no write and no done.
        issue(1, 3, 9, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_err_zero", 32'(err_zero), 0);
        rst = 1'b0;
        model_err = 0;
        repeat (30) @(negedge clk);
        probe(9, model_rf[9]);
        wait_quiet();
        load_poly(F_POLY);

        // Sweep every nonzero operand in random order with random addresses.
        for (int a = 1; a < (1 << M); a++) order.push_back(a);
        for (int i = order.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        foreach (order[k]) begin
            src = int'($urandom_range(0, DEPTH - 1));
            dst = int'($urandom_range(0, DEPTH - 1));
            host_write(src, order[k], 1'b1);
            issue(1, src, dst, 1'b1);
            wait_quiet();
        end

        wait_quiet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
